// File: rtl/fwd_pkg.sv
// fwd_pkg: shared slot record and EX bypass-mux select encoding for the hazard scoreboard.
package fwd_pkg;

    // Upper bound on REG_AW; narrower register addresses are zero-extended into the slot record.
    localparam int MAX_REG_AW = 8;

    localparam int FWD_SEL_RF  = 0;
    localparam int FWD_SEL_MEM = 1;
    localparam int FWD_SEL_WB  = 2;

    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] dest;
        logic                  wb_en;
        logic                  mem_read;
    } slot_t;

    // A producer k stages ahead of ID is one mux input further down the EX bypass mux.
    function automatic int stage_sel(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// fwd_src_match: youngest-producer priority encoder for one source operand against the in-flight slots.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int REG_AW     = 4,
    parameter int SEL_W      = $clog2(NUM_STAGES)
) (
    input  logic [REG_AW-1:0] src,
    input  logic              used,
    input  slot_t             slots [NUM_STAGES],
    output logic              hit,
    output logic              load_hit,
    output logic [SEL_W-1:0]  sel
);

    logic [NUM_STAGES-2:0] match;

    // The WB slot is excluded: the register file already returns its value this cycle.
    always_comb begin
        match = '0;
        for (int k = 0; k < NUM_STAGES - 1; k++)
            match[k] = used & slots[k].valid & slots[k].wb_en &
                       (slots[k].dest == MAX_REG_AW'(src));
    end

    assign hit      = |match;
    assign load_hit = match[0] & slots[0].mem_read;

    always_comb begin
        sel = SEL_W'(FWD_SEL_RF);
        for (int k = NUM_STAGES - 2; k >= 0; k--)
            if (match[k]) sel = SEL_W'(stage_sel(k));
    end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard: tracks in-flight destinations, raises load-use/no-forward stalls
// and registers the EX bypass selects for the instruction leaving ID.
module fwd_hazard_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int REG_AW     = 4,
    parameter int NUM_STAGES = 3,
    parameter int SEL_W      = $clog2(NUM_STAGES),
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fwd_en,
    input  logic                      freeze,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_dest,
    input  logic                      id_wb_en,
    input  logic                      id_mem_read,
    output logic                      stall,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic [CNT_W-1:0]          stall_cnt
);

    slot_t                    slots [NUM_STAGES];
    logic [NUM_SRC-1:0]       hit;
    logic [NUM_SRC-1:0]       load_hit;
    logic [NUM_SRC*SEL_W-1:0] sel;

    genvar i;
    generate
        for (i = 0; i < NUM_SRC; i++) begin : g_src
            fwd_src_match #(
                .NUM_STAGES(NUM_STAGES),
                .REG_AW    (REG_AW),
                .SEL_W     (SEL_W)
            ) u_match (
                .src     (id_src[i*REG_AW +: REG_AW]),
                .used    (id_src_used[i]),
                .slots   (slots),
                .hit     (hit[i]),
                .load_hit(load_hit[i]),
                .sel     (sel[i*SEL_W +: SEL_W])
            );
        end
    endgenerate

    // With forwarding only a load in EX cannot be bypassed; without it every un-retired producer blocks.
    assign stall = id_valid & ~flush & (fwd_en ? |load_hit : |hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++) slots[k] <= '0;
            fwd_sel   <= '0;
            stall_cnt <= '0;
        end else if (!freeze) begin
            for (int k = NUM_STAGES - 1; k > 0; k--) slots[k] <= slots[k-1];
            slots[0] <= '{valid:    id_valid & ~stall & ~flush,
                          dest:     MAX_REG_AW'(id_dest),
                          wb_en:    id_wb_en,
                          mem_read: id_mem_read};
            fwd_sel <= (fwd_en & ~stall & ~flush) ? sel : '0;
            if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// tb_fwd_hazard_scoreboard: directed scenarios plus randomized traffic against a queue-based pipeline model.
module tb_fwd_hazard_scoreboard;

    localparam int NS = 2, AW = 4, NST = 3, SW = 2, CW = 4;

    logic           clk = 0, rst = 1, fwd_en = 1, freeze = 0, flush = 0, id_valid = 0;
    logic [NS*AW-1:0] id_src = '0;
    logic [NS-1:0]  id_src_used = '0;
    logic [AW-1:0]  id_dest = '0;
    logic           id_wb_en = 0, id_mem_read = 0;
    logic           stall;
    logic [NS*SW-1:0] fwd_sel;
    logic [CW-1:0]  stall_cnt;

    fwd_hazard_scoreboard #(
        .NUM_SRC(NS), .REG_AW(AW), .NUM_STAGES(NST), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .stall(stall), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit       v;
        bit [3:0] d;
        bit       wb;
        bit       mr;
    } ent_t;

    int checks = 0, errors = 0;
    // mq[n] = instruction that left ID n+1 cycles ago (index 0 = EX, 1 = MEM, 2 = WB)
    ent_t mq[$];
    logic [NS*SW-1:0] m_sel = '0;
    int m_cnt = 0;
    logic obs_stall, exp_stall;
    logic [NS*SW-1:0] obs_sel;
    logic [CW-1:0] obs_cnt;

    function automatic bit writes(int d, logic [3:0] r);
        return mq[d].v && mq[d].wb && mq[d].d == r;
    endfunction

    function automatic bit model_stall();
        logic [3:0] r;
        if (!id_valid || flush) return 0;
        for (int i = 0; i < NS; i++) begin
            r = id_src[i*AW +: AW];
            if (id_src_used[i]) begin
                if (fwd_en && writes(0, r) && mq[0].mr) return 1;
                if (!fwd_en && (writes(0, r) || writes(1, r))) return 1;
            end
        end
        return 0;
    endfunction

    task automatic model_clear();
        mq.delete();
        repeat (NST) mq.push_back('0);
        m_sel = '0;
        m_cnt = 0;
    endtask

    task automatic tick();
        logic [NS*SW-1:0] ns;
        logic [3:0] r;
        ent_t e;
        #1;
        obs_stall = stall;
        exp_stall = model_stall();
        ns = '0;
        if (fwd_en && !exp_stall && !flush)
            for (int i = 0; i < NS; i++) begin
                r = id_src[i*AW +: AW];
                for (int d = NST - 2; d >= 0; d--)
                    if (id_src_used[i] && writes(d, r)) ns[i*SW +: SW] = SW'(d + 1);
            end
        @(posedge clk);
        if (rst) model_clear();
        else if (!freeze) begin
            e.v = id_valid && !exp_stall && !flush;
            e.d = id_dest;
            e.wb = id_wb_en;
            e.mr = id_mem_read;
            mq.push_front(e);
            void'(mq.pop_back());
            m_sel = ns;
            if (exp_stall && m_cnt < (1 << CW) - 1) m_cnt++;
        end
        #1;
        obs_sel = fwd_sel;
        obs_cnt = stall_cnt;
    endtask

    task automatic set_instr(bit v, bit [3:0] s0, bit [3:0] s1, bit [1:0] used, bit [3:0] d, bit wb, bit mr);
        id_valid = v;
        id_src = {s1, s0};
        id_src_used = used;
        id_dest = d;
        id_wb_en = wb;
        id_mem_read = mr;
    endtask

    task automatic drain();
        set_instr(0, 0, 0, 2'b00, 0, 0, 0);
        repeat (NST) tick();
    endtask

    task automatic test_reset();
        rst = 1;
        set_instr(0, 0, 0, 2'b00, 0, 0, 0);
        tick();
        tick();
        rst = 0;
        tick();
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", obs_stall); end
        checks++; if (obs_sel !== '0) begin errors++; $display("FAIL reset_fwd_sel: got %h want 0", obs_sel); end
        checks++; if (obs_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", obs_cnt); end
    endtask

    task automatic test_forward();
        fwd_en = 1;
        drain();
        set_instr(1, 1, 2, 2'b11, 3, 1, 0); tick();
        set_instr(1, 3, 3, 2'b11, 5, 1, 0); tick();
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL fwd_mem_stall: got %b want 0", obs_stall); end
        checks++; if (obs_sel !== 4'b0101) begin errors++; $display("FAIL fwd_mem_sel: got %b want 0101", obs_sel); end
        set_instr(1, 1, 2, 2'b11, 3, 1, 0); tick();
        set_instr(0, 0, 0, 2'b00, 0, 0, 0); tick();
        set_instr(1, 3, 3, 2'b11, 5, 1, 0); tick();
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL fwd_wb_stall: got %b want 0", obs_stall); end
        checks++; if (obs_sel !== 4'b1010) begin errors++; $display("FAIL fwd_wb_sel: got %b want 1010", obs_sel); end
    endtask

    task automatic test_load_use();
        logic [CW-1:0] c0;
        fwd_en = 1;
        drain();
        c0 = obs_cnt;
        set_instr(1, 0, 0, 2'b00, 2, 1, 1); tick();
        set_instr(1, 2, 1, 2'b11, 4, 1, 0); tick();
        checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL lu_stall1: got %b want 1", obs_stall); end
        tick();
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL lu_stall2: got %b want 0", obs_stall); end
        checks++; if (obs_sel !== 4'b0010) begin errors++; $display("FAIL lu_sel: got %b want 0010", obs_sel); end
        checks++; if (obs_cnt !== CW'(c0 + 1)) begin errors++; $display("FAIL lu_cnt: got %0d want %0d", obs_cnt, CW'(c0 + 1)); end
    endtask

    task automatic test_stall_only();
        logic [CW-1:0] c0;
        int n;
        bit done;
        fwd_en = 0;
        drain();
        c0 = obs_cnt;
        n = 0;
        done = 0;
        set_instr(1, 0, 0, 2'b00, 2, 1, 1); tick();
        set_instr(1, 2, 1, 2'b11, 4, 1, 0);
        for (int k = 0; k < 6 && !done; k++) begin
            tick();
            checks++; if (obs_sel !== '0) begin errors++; $display("FAIL so_sel: got %b want 0", obs_sel); end
            if (obs_stall) n++;
            else done = 1;
        end
        checks++; if (!done || n != NST - 1) begin errors++; $display("FAIL so_stall_cycles: got %0d want %0d", n, NST - 1); end
        checks++; if (obs_cnt !== CW'(c0 + 2)) begin errors++; $display("FAIL so_cnt: got %0d want %0d", obs_cnt, CW'(c0 + 2)); end
    endtask

    task automatic test_youngest();
        fwd_en = 1;
        drain();
        set_instr(1, 0, 0, 2'b00, 3, 1, 0); tick();
        set_instr(1, 0, 0, 2'b00, 3, 1, 0); tick();
        set_instr(1, 3, 3, 2'b11, 5, 1, 0); tick();
        checks++; if (obs_sel !== 4'b0101) begin errors++; $display("FAIL youngest_sel: got %b want 0101", obs_sel); end
    endtask

    task automatic test_flush();
        fwd_en = 1;
        drain();
        set_instr(1, 0, 0, 2'b00, 2, 1, 1); tick();
        set_instr(1, 2, 1, 2'b11, 4, 1, 0);
        flush = 1; tick();
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", obs_stall); end
        checks++; if (obs_sel !== '0) begin errors++; $display("FAIL flush_sel: got %b want 0", obs_sel); end
        flush = 0; tick();
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL flush_bubble_stall: got %b want 0", obs_stall); end
        checks++; if (obs_sel !== 4'b0010) begin errors++; $display("FAIL flush_bubble_sel: got %b want 0010", obs_sel); end
    endtask

    task automatic test_freeze();
        logic [CW-1:0] c0;
        logic [NS*SW-1:0] s0;
        fwd_en = 1;
        drain();
        c0 = obs_cnt;
        set_instr(1, 0, 0, 2'b00, 2, 1, 1); tick();
        s0 = obs_sel;
        set_instr(1, 2, 1, 2'b11, 4, 1, 0);
        freeze = 1;
        repeat (5) begin
            tick();
            checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL frz_stall: got %b want 1", obs_stall); end
            checks++; if (obs_sel !== s0 || obs_cnt !== c0) begin errors++; $display("FAIL frz_hold: got sel %b cnt %0d want sel %b cnt %0d", obs_sel, obs_cnt, s0, c0); end
        end
        freeze = 0;
        tick();
        checks++; if (obs_stall !== 1'b1 || obs_cnt !== CW'(c0 + 1)) begin errors++; $display("FAIL frz_release: got stall %b cnt %0d want 1 %0d", obs_stall, obs_cnt, CW'(c0 + 1)); end
        tick();
        checks++; if (obs_stall !== 1'b0 || obs_sel !== 4'b0010) begin errors++; $display("FAIL frz_after: got stall %b sel %b want 0 0010", obs_stall, obs_sel); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) fwd_en = $urandom_range(0, 1);
            rst = ($urandom_range(0, 149) == 0);
            freeze = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 9) == 0);
            set_instr($urandom_range(0, 9) < 8, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                      $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3);
            tick();
            checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall c%0d: got %b want %b", c, obs_stall, exp_stall); end
            checks++; if (obs_sel !== m_sel) begin errors++; $display("FAIL rnd_sel c%0d: got %b want %b", c, obs_sel, m_sel); end
            checks++; if (obs_cnt !== CW'(m_cnt)) begin errors++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, obs_cnt, m_cnt); end
        end
        rst = 0; freeze = 0; flush = 0;
    endtask

    task automatic test_saturation();
        fwd_en = 0;
        repeat (12) begin
            set_instr(1, 0, 0, 2'b00, 2, 1, 1); tick();
            set_instr(1, 2, 1, 2'b11, 4, 1, 0); tick(); tick(); tick();
        end
        checks++; if (obs_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt: got %0d want 15", obs_cnt); end
        tick();
        checks++; if (obs_cnt !== CW'(m_cnt)) begin errors++; $display("FAIL sat_model: got %0d want %0d", obs_cnt, m_cnt); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_forward();
        test_load_use();
        test_stall_only();
        test_youngest();
        test_flush();
        test_freeze();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
